// File: rtl/ysyx_25030093_idu_queue.sv
// ysyx_25030093_idu_queue
// Buffered instruction-decode stage. {pc, inst} pairs from the IFU are queued
// in a DEPTH-entry FIFO. The head is decoded to the 6-bit ALU operation code
// and registered toward the EXU behind a valid/ready port.
//
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   flush             - synchronous clear of the FIFO and the output register
//   in_valid/in_ready - IFU handshake; in_pc, in_inst carry the fetch
//   out_valid/out_ready - EXU handshake for the registered decoded bundle
//   out_pc, out_alu_op, out_pc_sel, out_wen, out_rs_read, out_imm,
//   out_rd, out_rs1, out_rs2, out_illegal, out_ebreak - decoded bundle
//   occupancy         - number of FIFO entries, not counting the output register
module ysyx_25030093_idu_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter bit EN_M  = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [5:0]                 out_alu_op,
  output logic [1:0]                 out_pc_sel,
  output logic                       out_wen,
  output logic                       out_rs_read,
  output logic [XLEN-1:0]            out_imm,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic                       out_illegal,
  output logic                       out_ebreak,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_inst;

  // FIFO handshake. in_ready depends only on the count, so a full FIFO
  // refuses a push even if an entry leaves in the same cycle.
  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid & in_ready;
  assign pop       = (count != '0) & (~out_valid | out_ready);
  assign occupancy = count;
  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];

  // Entry storage needs no reset: only slots covered by the count are read.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  // Pointers and count. DEPTH is a power of two, so the pointers wrap
  // naturally. Flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [5:0]  dec_alu_op;
  logic [1:0]  dec_pc_sel;
  logic        dec_wen;
  logic        dec_rs_read;
  logic        dec_illegal;
  logic        dec_ebreak;
  imm_sel_e    imm_sel;
  logic [31:0] imm32;
  logic [XLEN+31:0] imm_wide;
  logic [XLEN-1:0]  dec_imm;

  assign opcode = head_inst[6:0];
  assign funct3 = head_inst[14:12];
  assign funct7 = head_inst[31:25];

  // Decoder. Everything starts out illegal with all controls cleared; only
  // an exact opcode/funct3/funct7 match turns an encoding legal, so every
  // unrecognised pattern falls through with alu_op=0, wen=0, rs_read=0,
  // pc_sel=0. Note bne deliberately leaves rs_read low.
  always_comb begin
    dec_alu_op  = 6'd0;
    dec_pc_sel  = 2'd0;
    dec_wen     = 1'b0;
    dec_rs_read = 1'b0;
    dec_illegal = 1'b1;
    dec_ebreak  = 1'b0;
    imm_sel     = IMM_I;
    case (opcode)
      OPC_LUI: begin
        dec_illegal = 1'b0; dec_alu_op = 6'd2; dec_wen = 1'b1; imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        dec_illegal = 1'b0; dec_alu_op = 6'd1; dec_wen = 1'b1; imm_sel = IMM_U;
      end
      OPC_JAL: begin
        dec_illegal = 1'b0; dec_alu_op = 6'd3; dec_wen = 1'b1;
        dec_pc_sel  = 2'd2; imm_sel = IMM_J;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          dec_illegal = 1'b0; dec_alu_op = 6'd3; dec_wen = 1'b1; dec_pc_sel = 2'd1;
        end
      end
      OPC_BRANCH: begin
        dec_illegal = 1'b0; dec_pc_sel = 2'd3; dec_rs_read = 1'b1; imm_sel = IMM_B;
        case (funct3)
          3'b000:  dec_alu_op = 6'd4;
          3'b001: begin dec_alu_op = 6'd8; dec_rs_read = 1'b0; end
          3'b100:  dec_alu_op = 6'd19;
          3'b101:  dec_alu_op = 6'd14;
          3'b110:  dec_alu_op = 6'd20;
          3'b111:  dec_alu_op = 6'd21;
          default: begin dec_illegal = 1'b1; dec_pc_sel = 2'd0; dec_rs_read = 1'b0; end
        endcase
      end
      OPC_LOAD: begin
        dec_illegal = 1'b0; dec_wen = 1'b1; dec_rs_read = 1'b1;
        case (funct3)
          3'b000:  dec_alu_op = 6'd31;
          3'b001:  dec_alu_op = 6'd32;
          3'b010:  dec_alu_op = 6'd6;
          3'b100:  dec_alu_op = 6'd26;
          3'b101:  dec_alu_op = 6'd35;
          default: begin dec_illegal = 1'b1; dec_wen = 1'b0; dec_rs_read = 1'b0; end
        endcase
      end
      OPC_STORE: begin
        dec_illegal = 1'b0; dec_rs_read = 1'b1; imm_sel = IMM_S;
        case (funct3)
          3'b000:  dec_alu_op = 6'd28;
          3'b001:  dec_alu_op = 6'd29;
          3'b010:  dec_alu_op = 6'd5;
          default: begin dec_illegal = 1'b1; dec_rs_read = 1'b0; end
        endcase
      end
      OPC_OPIMM: begin
        dec_illegal = 1'b0; dec_wen = 1'b1; dec_rs_read = 1'b1;
        case (funct3)
          3'b000: dec_alu_op = 6'd0;
          3'b010: dec_alu_op = 6'd18;
          3'b011: dec_alu_op = 6'd7;
          3'b100: dec_alu_op = 6'd24;
          3'b110: dec_alu_op = 6'd25;
          3'b111: dec_alu_op = 6'd16;
          3'b001: begin
            if (funct7 == 7'b0000000) dec_alu_op = 6'd15;
            else begin dec_illegal = 1'b1; dec_wen = 1'b0; dec_rs_read = 1'b0; end
          end
          default: begin
            if (funct7 == 7'b0000000)      dec_alu_op = 6'd17;
            else if (funct7 == 7'b0100000) dec_alu_op = 6'd27;
            else begin dec_illegal = 1'b1; dec_wen = 1'b0; dec_rs_read = 1'b0; end
          end
        endcase
      end
      OPC_OP: begin
        dec_illegal = 1'b0; dec_wen = 1'b1; dec_rs_read = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec_alu_op = 6'd9;
            3'b001:  dec_alu_op = 6'd22;
            3'b010:  dec_alu_op = 6'd23;
            3'b011:  dec_alu_op = 6'd13;
            3'b100:  dec_alu_op = 6'd12;
            3'b101:  dec_alu_op = 6'd33;
            3'b110:  dec_alu_op = 6'd11;
            default: dec_alu_op = 6'd30;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_alu_op = 6'd10;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec_alu_op = 6'd34;
        end else if (funct7 == 7'b0000001 && EN_M) begin
          // mul, mulh, mulhsu, mulhu, div, divu, rem, remu follow funct3
          dec_alu_op = 6'd36 + {3'b000, funct3};
        end else begin
          dec_illegal = 1'b1; dec_wen = 1'b0; dec_rs_read = 1'b0;
        end
      end
      OPC_FENCE: begin
        dec_illegal = 1'b0;
      end
      OPC_SYSTEM: begin
        if (head_inst == INST_EBREAK) begin
          dec_illegal = 1'b0;
          dec_ebreak  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Immediate formats, all sign-extended from bit 31 before widening to XLEN.
  always_comb begin
    imm32 = {{20{head_inst[31]}}, head_inst[31:20]};
    case (imm_sel)
      IMM_S: imm32 = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
      IMM_B: imm32 = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                      head_inst[30:25], head_inst[11:8], 1'b0};
      IMM_U: imm32 = {head_inst[31:12], 12'b0};
      IMM_J: imm32 = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                      head_inst[20], head_inst[30:21], 1'b0};
      default: ;
    endcase
  end

  assign imm_wide = {{XLEN{imm32[31]}}, imm32};
  assign dec_imm  = imm_wide[XLEN-1:0];

  // Output register. It loads whenever the head is popped; otherwise a
  // consumed bundle with nothing behind it drops out_valid, and a stalled
  // bundle keeps every field untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_alu_op  <= '0;
      out_pc_sel  <= '0;
      out_wen     <= 1'b0;
      out_rs_read <= 1'b0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_illegal <= 1'b0;
      out_ebreak  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid   <= 1'b1;
      out_pc      <= head_pc;
      out_alu_op  <= dec_alu_op;
      out_pc_sel  <= dec_pc_sel;
      out_wen     <= dec_wen;
      out_rs_read <= dec_rs_read;
      out_imm     <= dec_imm;
      out_rd      <= head_inst[11:7];
      out_rs1     <= head_inst[19:15];
      out_rs2     <= head_inst[24:20];
      out_illegal <= dec_illegal;
      out_ebreak  <= dec_ebreak;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
